// File: rtl/bit_iter_pkg.sv
// rtl/bit_iter_pkg.sv - shared state encoding and width helper for bit_iter
package bit_iter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Word width from log2 width.
  function automatic int word_width(input int order);
    return 1 << order;
  endfunction

endpackage

// File: rtl/bit_iter_find.sv
// rtl/bit_iter_find.sv - recursive priority encoder over a set-bit mask
//
// Ports:
//   mask    in   word to search
//   index   out  lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit; don't-care when zero
//   zero    out  mask has no bits set
//   single  out  mask has at most one bit set
module bit_find
  import bit_iter_pkg::*;
#(
  parameter int ORDER     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [word_width(ORDER)-1:0] mask,
  output logic [ORDER-1:0]             index,
  output logic                         zero,
  output logic                         single
);

  localparam int W = word_width(ORDER);
  localparam int H = W / 2;

  generate
    if (ORDER == 1) begin : g_leaf
      assign zero   = ~(mask[0] | mask[1]);
      assign single = ~(mask[0] & mask[1]);
      if (MSB_FIRST) begin : g_msb
        assign index = mask[1];
      end else begin : g_lsb
        assign index = ~mask[0];
      end
    end else begin : g_split
      logic [ORDER-2:0] idx_lo, idx_hi;
      logic             zero_lo, zero_hi, single_lo, single_hi;

      bit_find #(.ORDER(ORDER-1), .MSB_FIRST(MSB_FIRST)) u_lo (
        .mask   (mask[H-1:0]),
        .index  (idx_lo),
        .zero   (zero_lo),
        .single (single_lo)
      );

      bit_find #(.ORDER(ORDER-1), .MSB_FIRST(MSB_FIRST)) u_hi (
        .mask   (mask[W-1:H]),
        .index  (idx_hi),
        .zero   (zero_hi),
        .single (single_hi)
      );

      assign zero   = zero_lo & zero_hi;
      // At most one bit overall: one half empty, the other holding at most one.
      assign single = (zero_lo & single_hi) | (zero_hi & single_lo);

      if (MSB_FIRST) begin : g_msb
        assign index = zero_hi ? {1'b0, idx_lo} : {1'b1, idx_hi};
      end else begin : g_lsb
        assign index = zero_lo ? {1'b1, idx_hi} : {1'b0, idx_lo};
      end
    end
  endgenerate

endmodule

// File: rtl/bit_iter.sv
// rtl/bit_iter.sv - streaming set-bit iterator, one index per output beat
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   input word present
//   in_ready   out  word accepted on in_valid & in_ready
//   in_data    in   word to iterate
//   out_valid  out  index beat present
//   out_ready  in   beat consumed on out_valid & out_ready
//   out_index  out  bit position of the current set bit
//   out_seq    out  ordinal of the beat within the word
//   out_last   out  final beat of the word
//   out_none   out  word was all zeros, beat carries no index
module bit_iter
  import bit_iter_pkg::*;
#(
  parameter int ORDER     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [word_width(ORDER)-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ORDER-1:0]             out_index,
  output logic [ORDER:0]               out_seq,
  output logic                         out_last,
  output logic                         out_none
);

  localparam int W = word_width(ORDER);

  state_e           state_q, state_d;
  logic [W-1:0]     mask_q, mask_d;
  logic [ORDER:0]   seq_q, seq_d;
  logic             none_q, none_d;

  logic [ORDER-1:0] find_idx;
  logic             find_zero, find_single;
  logic             fire_in, fire_out;
  logic [W-1:0]     mask_next;

  bit_find #(.ORDER(ORDER), .MSB_FIRST(MSB_FIRST)) u_find (
    .mask   (mask_q),
    .index  (find_idx),
    .zero   (find_zero),
    .single (find_single)
  );

  always_comb begin
    out_valid = (state_q == ST_EMIT);
    out_index = (out_valid && !find_zero) ? find_idx : '0;
    out_last  = out_valid & find_single;
    out_seq   = seq_q;
    out_none  = out_valid & none_q;
    // A new word may enter in the same cycle the last beat leaves.
    in_ready  = (state_q == ST_IDLE) | (out_valid & out_ready & out_last);

    fire_in   = in_valid & in_ready;
    fire_out  = out_valid & out_ready;

    if (MSB_FIRST) begin
      mask_next = mask_q & ~({{(W-1){1'b0}}, 1'b1} << find_idx);
    end else begin
      mask_next = mask_q & (mask_q - {{(W-1){1'b0}}, 1'b1});
    end

    state_d = state_q;
    mask_d  = mask_q;
    seq_d   = seq_q;
    none_d  = none_q;

    if (fire_in) begin
      state_d = ST_EMIT;
      mask_d  = in_data;
      seq_d   = '0;
      none_d  = (in_data == '0);
    end else if (fire_out && out_last) begin
      state_d = ST_IDLE;
      mask_d  = '0;
      seq_d   = '0;
      none_d  = 1'b0;
    end else if (fire_out) begin
      mask_d  = mask_next;
      seq_d   = seq_q + {{ORDER{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      seq_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: doc/bit_iter.md
Name: bit_iter

Overview:
- Streaming set-bit iterator. Performs the inverse of the count/scan blocks (popcount, ctz, clz): it expands one W-bit word into the index of each set bit, one index per output beat.
- Feeds scheduler, arbiter and free-list logic that must visit set bits serially.
- Valid/ready handshake on both sides, so it can sit between any producer and consumer in the fabric.

Parameters:
- ORDER, 3, log2 of word width; W = 2**ORDER.
- MSB_FIRST, 0, scan order: 0 = lowest set bit first (ctz order); 1 = highest set bit first (clz order).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  word accepted when in_valid & in_ready at a clock edge.
- in_data  in  W  word to iterate.
- out_valid  out  1  index beat present.
- out_ready  in  1  beat consumed when out_valid & out_ready at a clock edge.
- out_index  out  ORDER  bit position of the current set bit.
- out_seq  out  ORDER+1  ordinal of the beat within the word, starting at 0.
- out_last  out  1  current beat is the final beat of the word.
- out_none  out  1  word was all zeros; the beat carries no index.

Behaviour:
- States: IDLE, EMIT. A registered mask holds the bits still to be emitted. A registered seq counter has ORDER+1 bits.
- Reset (reset low, takes effect immediately):
  - state=IDLE, mask=0, seq=0, out_none=0.
  - Outputs: out_valid=0, in_ready=1, out_index=0, out_seq=0, out_last=0, out_none=0.
  - Any word in progress is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On accept: mask<=in_data, seq<=0, out_none<=(in_data==0), state<=EMIT.
  - Latency is 1 cycle: out_valid=1 in the cycle after the accept.
- EMIT:
  - out_valid=1.
  - out_index is combinational from mask: the lowest set bit (MSB_FIRST=0) or the highest set bit (MSB_FIRST=1).
  - out_last=1 when mask has at most one set bit.
  - out_seq=seq.
- Beat consumed, not last: clear the emitted bit in mask, seq<=seq+1.
  - LSB order clears with mask&(mask-1).
  - MSB order clears the bit at out_index.
- Zero word: exactly one beat with out_none=1, out_last=1, out_index=0, out_seq=0.
- Word completion and back-to-back loading:
  - in_ready = IDLE | (EMIT & out_valid & out_ready & out_last).
  - When the last beat is consumed and a new word is accepted in the same cycle, load the new word and stay in EMIT. This gives zero bubble between words.
  - When the last beat is consumed and no word arrives, go to IDLE.
- Backpressure: while out_valid & ~out_ready, mask, seq and all out_* stay stable.
- Beat count equals popcount(in_data), or 1 for a zero word. On the last beat, out_seq = popcount-1.
- Full word (all ones) gives W beats. out_seq reaches W-1 and never wraps.
- in_data is sampled only on accept. Changes to it at other times have no effect.

Decomposition:
- Shared package bit_iter_pkg: state encoding constants (ST_IDLE, ST_EMIT) and the W = 2**ORDER width helper.
- One sub-module: bit_find #(ORDER, MSB_FIRST).
  - Combinational priority encoder over mask.
  - Outputs index, a zero flag, and a single flag (at most one bit set).
  - Implemented recursively by halves, like the existing scan blocks.

Test Plan (ORDER=3, W=8):
- Reset: drive reset low mid-simulation -> out_valid=0 and in_ready=1 immediately, before any clock edge.
- LSB order, 8'hA5, out_ready=1:
  - out_index 0,2,5,7 on four consecutive cycles; out_seq 0,1,2,3.
  - out_last only on index 7.
  - in_ready=1 in that same cycle.
- Zero word 8'h00 -> exactly one beat: out_none=1, out_last=1, out_index=0, out_seq=0; then IDLE.
- Backpressure, 8'h0C with out_ready=0 for 3 cycles -> index 2 held, seq 0 held; then out_ready=1 -> indices 2, then 3 (last).
- MSB_FIRST=1:
  - 8'h81 -> indices 7, then 0 (last).
  - 8'hFF -> 7..0 with out_seq 0..7.
- Back-to-back words 8'h01 then 8'h80, in_valid held -> index 0 (last), then index 7 (last) on the next cycle, no bubble.
- Reset mid-word: 8'hFF, assert reset after 3 beats -> out_valid=0 immediately; after release, 8'h02 yields a single beat, index 1, seq 0.
